// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
package pipe_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic       is_rs2;
        logic       rd_wren;
        logic       is_load;
        logic       mem_wren;
        logic       op_sel_a;
        logic       op_sel_b;
        logic       br_unsigned;
        logic [1:0] wb_sel;
        logic [2:0] mem_op;
        alu_op_e    alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic       rd_wren;
        logic       is_load;
        logic       mem_wren;
        logic [1:0] wb_sel;
        logic [2:0] mem_op;
    } mem_ctrl_t;

endpackage

// File: rtl/ex_stage_imm_gen.sv
// Sign-extended immediate decode for RV32I formats; unknown opcodes give 0.
module imm_gen
    import pipe_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Select the immediate format from the opcode.
    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, load-use
// detection and the EX/MEM pipeline register.
module ex_stage
    import pipe_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  ex_ctrl_t        ctrl_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            wb_rd_wren_i,
    input  logic [4:0]      wb_rd_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [XLEN-1:0] id_instr_i,
    output mem_ctrl_t       ctrl_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] alu_data_o,
    output logic [XLEN-1:0] store_data_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            ld_use_stall_o
);

    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr, rs2_addr, rd_addr, exm_rd;
    logic            exm_fwd_ok, wb_fwd_ok;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_result;
    logic            br_taken, is_branch, is_jal, is_jalr;
    logic            unused_id_bits;

    imm_gen u_imm_gen (
        .instr (instr_i),
        .imm   (imm)
    );

    assign rs1_addr = instr_i[19:15];
    assign rs2_addr = instr_i[24:20];
    assign rd_addr  = instr_i[11:7];
    assign exm_rd   = instr_o[11:7];

    // Loads in EX/MEM have no data yet; those cases are covered by the stall.
    assign exm_fwd_ok = ctrl_o.rd_wren && !ctrl_o.is_load && (exm_rd != 5'd0);
    assign wb_fwd_ok  = wb_rd_wren_i && (wb_rd_addr_i != 5'd0);

    // Resolve source operands: EX/MEM first, then WB, then register file.
    always_comb begin
        fwd_rs1 = rs1_data_i;
        if (rs1_addr == 5'd0)
            fwd_rs1 = '0;
        else if (exm_fwd_ok && exm_rd == rs1_addr)
            fwd_rs1 = alu_data_o;
        else if (wb_fwd_ok && wb_rd_addr_i == rs1_addr)
            fwd_rs1 = wb_data_i;

        fwd_rs2 = rs2_data_i;
        if (rs2_addr == 5'd0)
            fwd_rs2 = '0;
        else if (ctrl_i.is_rs2 && exm_fwd_ok && exm_rd == rs2_addr)
            fwd_rs2 = alu_data_o;
        else if (ctrl_i.is_rs2 && wb_fwd_ok && wb_rd_addr_i == rs2_addr)
            fwd_rs2 = wb_data_i;
    end

    assign op_a = ctrl_i.op_sel_a ? pc_i : fwd_rs1;
    assign op_b = ctrl_i.op_sel_b ? imm  : fwd_rs2;

    // ALU operation select.
    always_comb begin
        alu_result = '0;
        case (ctrl_i.alu_op)
            ALU_ADD:   alu_result = op_a + op_b;
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_SLL:   alu_result = op_a << op_b[4:0];
            ALU_SLT:   alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_result = {31'b0, op_a < op_b};
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_SRL:   alu_result = op_a >> op_b[4:0];
            ALU_SRA:   alu_result = $signed(op_a) >>> op_b[4:0];
            ALU_OR:    alu_result = op_a | op_b;
            ALU_AND:   alu_result = op_a & op_b;
            ALU_PASSB: alu_result = op_b;
            default:   alu_result = '0;
        endcase
    end

    assign is_branch = (instr_i[6:0] == OP_BRANCH);
    assign is_jal    = (instr_i[6:0] == OP_JAL);
    assign is_jalr   = (instr_i[6:0] == OP_JALR);

    // Branch condition on forwarded operands; funct3 bit 1 is ignored for LT/GE.
    always_comb begin
        br_taken = 1'b0;
        if (is_branch) begin
            case (instr_i[14:12])
                3'b000: br_taken = (fwd_rs1 == fwd_rs2);
                3'b001: br_taken = (fwd_rs1 != fwd_rs2);
                3'b100, 3'b110:
                    br_taken = ctrl_i.br_unsigned ? (fwd_rs1 < fwd_rs2)
                                                  : ($signed(fwd_rs1) < $signed(fwd_rs2));
                3'b101, 3'b111:
                    br_taken = ctrl_i.br_unsigned ? (fwd_rs1 >= fwd_rs2)
                                                  : ($signed(fwd_rs1) >= $signed(fwd_rs2));
                default: br_taken = 1'b0;
            endcase
        end
    end

    // Redirect request and target; held stage must not re-issue a redirect.
    always_comb begin
        redirect_pc_o = pc_i + 32'd4;
        if (is_jal)
            redirect_pc_o = pc_i + imm;
        else if (is_jalr)
            redirect_pc_o = (fwd_rs1 + imm) & ~32'd1;
        else if (br_taken)
            redirect_pc_o = pc_i + imm;
    end

    assign redirect_o = enable_i && (br_taken || is_jal || is_jalr);

    // Conservative: any rs1/rs2 field match counts, used or not.
    assign ld_use_stall_o = ctrl_i.is_load && ctrl_i.rd_wren && (rd_addr != 5'd0) &&
                            ((rd_addr == id_instr_i[19:15]) || (rd_addr == id_instr_i[24:20]));

    assign unused_id_bits = ^{id_instr_i[31:25], id_instr_i[14:0]};

    // EX/MEM pipeline register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_o       <= '0;
            pc_o         <= '0;
            instr_o      <= NOP_INSTR;
            alu_data_o   <= '0;
            store_data_o <= '0;
        end else if (enable_i) begin
            ctrl_o.rd_wren  <= ctrl_i.rd_wren;
            ctrl_o.is_load  <= ctrl_i.is_load;
            ctrl_o.mem_wren <= ctrl_i.mem_wren;
            ctrl_o.wb_sel   <= ctrl_i.wb_sel;
            ctrl_o.mem_op   <= ctrl_i.mem_op;
            pc_o            <= pc_i;
            instr_o         <= instr_i;
            alu_data_o      <= (ctrl_i.wb_sel == WB_PC4) ? pc_i + 32'd4 : alu_result;
            store_data_o    <= fwd_rs2;
        end
    end

endmodule
